// File: rtl/bram_drain_pkg.sv
// Shared types and default sizing for the BRAM drain-to-AXI-Stream block.
package bram_drain_pkg;

  localparam int DEF_DW         = 16;
  localparam int DEF_NUM_BRAMS  = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DEPTH      = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } drain_state_e;

endpackage

// File: rtl/bram_drain_row_serializer.sv
// Row buffer plus NUM_BRAMS-to-1 word serializer driving the AXI-Stream
// beat registers. A load (re)fills the buffer and presents word 0; each
// handshake advances the beat index. A load wins over a handshake, which lets
// the parent swap in a prefetched row on the final handshake of a row.
module bram_drain_row_serializer
  import bram_drain_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int NUM_BRAMS = DEF_NUM_BRAMS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NUM_BRAMS*DW-1:0] load_data,
  input  logic                   load_last,
  input  logic                   m_axis_tready,
  output logic [DW-1:0]          m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   last_hs
);

  localparam int                 IDX_W       = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_BRAMS - 1);
  localparam logic               SINGLE_WORD = (NUM_BRAMS == 1);

  logic [DW-1:0]    row_r [NUM_BRAMS];
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] next_idx_s;
  logic             last_row_r;
  logic [DW-1:0]    tdata_r;
  logic             tvalid_r;
  logic             tlast_r;

  assign next_idx_s    = idx_r + IDX_W'(1'b1);
  assign last_hs       = tvalid_r && m_axis_tready && (idx_r == LAST_IDX);
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;

  // Load a fresh row or step to the next word on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BRAMS; i++) row_r[i] <= {DW{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      last_row_r <= 1'b0;
      tdata_r    <= {DW{1'b0}};
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NUM_BRAMS; i++) row_r[i] <= load_data[i*DW +: DW];
      idx_r      <= {IDX_W{1'b0}};
      last_row_r <= load_last;
      tdata_r    <= load_data[DW-1:0];
      tvalid_r   <= 1'b1;
      tlast_r    <= load_last && SINGLE_WORD;
    end else if (tvalid_r && m_axis_tready) begin
      if (idx_r == LAST_IDX) begin
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
      end else begin
        idx_r   <= next_idx_s;
        tdata_r <= row_r[next_idx_s];
        tlast_r <= last_row_r && (next_idx_s == LAST_IDX);
      end
    end else begin
      tvalid_r <= tvalid_r;
    end
  end

endmodule

// File: rtl/bram_drain_axis_tx.sv
// Drains NUM_BRAMS parallel BRAMs row by row onto one AXI-Stream, BRAM 0
// word first. Rows are read from (base_addr + r) mod DEPTH.
// Optional feature macro: BRAM_DRAIN_PREFETCH_EN -- when defined, the next row
// is fetched into a second buffer while the current row is sent, so rows
// stream back-to-back; otherwise each row costs a FETCH/LATCH gap.
module bram_drain_axis_tx
  import bram_drain_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int NUM_BRAMS  = DEF_NUM_BRAMS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_rows,
  output logic                           ext_read_mode,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]        bram_read_data_flat,
  output logic [DW-1:0]                  m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic                           done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH:0]   ROWS_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   ROWS_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Next row address, wrapping from DEPTH-1 back to 0.
  function automatic logic [ADDR_WIDTH-1:0] next_row_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a >= LAST_ADDR) return ADDR_ZERO;
    else                return a + ADDR_WIDTH'(1'b1);
  endfunction

  drain_state_e            state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;       // address currently driven to the BRAMs
  logic [ADDR_WIDTH-1:0]   next_addr_r;  // address of the following row
  logic [ADDR_WIDTH:0]     rows_rem_r;   // rows still to fetch after the one at addr_r
  logic                    read_mode_r;
  logic                    busy_r;
  logic                    done_r;

  logic                    load_s;
  logic [NUM_BRAMS*DW-1:0] load_data_s;
  logic                    load_last_s;
  logic                    last_hs_s;

`ifdef BRAM_DRAIN_PREFETCH_EN
  logic [NUM_BRAMS*DW-1:0] pf_buf_r;     // prefetched next row
  logic [1:0]              pf_cnt_r;     // cycles until read data for the prefetch is valid
  logic                    pf_have_r;    // a next row has been (or is being) prefetched
`endif

  assign ext_read_mode      = read_mode_r;
  assign ext_read_addr_flat = {NUM_BRAMS{addr_r}};
  assign busy               = busy_r;
  assign done               = done_r;

  // Choose when and what the serializer loads: freshly read data in LATCH,
  // or the prefetched row on the final handshake of the current row.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = bram_read_data_flat;
    load_last_s = (rows_rem_r == ROWS_ZERO);
    if (state_r == ST_LATCH) begin
      load_s = 1'b1;
`ifdef BRAM_DRAIN_PREFETCH_EN
    end else if ((state_r == ST_SEND) && last_hs_s && pf_have_r) begin
      load_s      = 1'b1;
      load_data_s = pf_buf_r;
`endif
    end else begin
      load_s = 1'b0;
    end
  end

  // Drain sequencer: state, row bookkeeping and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_ZERO;
      next_addr_r <= ADDR_ZERO;
      rows_rem_r  <= ROWS_ZERO;
      read_mode_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef BRAM_DRAIN_PREFETCH_EN
      pf_buf_r    <= {(NUM_BRAMS*DW){1'b0}};
      pf_cnt_r    <= 2'd0;
      pf_have_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (num_rows == ROWS_ZERO) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_FETCH;
              read_mode_r <= 1'b1;
              addr_r      <= base_addr;
              next_addr_r <= next_row_addr(base_addr);
              rows_rem_r  <= num_rows - ROWS_ONE;
            end
          end else begin
            busy_r      <= 1'b0;
            read_mode_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          state_r <= ST_SEND;
`ifdef BRAM_DRAIN_PREFETCH_EN
          if (rows_rem_r != ROWS_ZERO) begin
            addr_r      <= next_addr_r;
            next_addr_r <= next_row_addr(next_addr_r);
            rows_rem_r  <= rows_rem_r - ROWS_ONE;
            pf_cnt_r    <= 2'd2;
            pf_have_r   <= 1'b1;
          end else begin
            pf_have_r   <= 1'b0;
          end
`endif
        end
        ST_SEND: begin
`ifdef BRAM_DRAIN_PREFETCH_EN
          if (pf_cnt_r == 2'd1) pf_buf_r <= bram_read_data_flat;
          if (pf_cnt_r != 2'd0) pf_cnt_r <= pf_cnt_r - 2'd1;
          if (last_hs_s) begin
            if (pf_have_r) begin
              if (rows_rem_r != ROWS_ZERO) begin
                addr_r      <= next_addr_r;
                next_addr_r <= next_row_addr(next_addr_r);
                rows_rem_r  <= rows_rem_r - ROWS_ONE;
                pf_cnt_r    <= 2'd2;
              end else begin
                pf_have_r   <= 1'b0;
              end
            end else begin
              state_r     <= ST_DONE;
              read_mode_r <= 1'b0;
              done_r      <= 1'b1;
            end
          end
`else
          if (last_hs_s) begin
            if (rows_rem_r != ROWS_ZERO) begin
              state_r     <= ST_FETCH;
              addr_r      <= next_addr_r;
              next_addr_r <= next_row_addr(next_addr_r);
              rows_rem_r  <= rows_rem_r - ROWS_ONE;
            end else begin
              state_r     <= ST_DONE;
              read_mode_r <= 1'b0;
              done_r      <= 1'b1;
            end
          end
`endif
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          read_mode_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          read_mode_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  bram_drain_row_serializer #(
    .DW        (DW),
    .NUM_BRAMS (NUM_BRAMS)
  ) u_serializer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load_s),
    .load_data     (load_data_s),
    .load_last     (load_last_s),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .last_hs       (last_hs_s)
  );

endmodule

// File: tb/tb_bram_drain_axis_tx.sv
// Self-checking bench for bram_drain_axis_tx: a registered-read BRAM array
// model, a beat monitor, and an expected stream computed from the row rules.
module tb_bram_drain_axis_tx;
  import bram_drain_pkg::*;

  localparam int DW = 16, NB = 16, AW = 9, DEPTH = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_rows = '0;
  logic              ext_read_mode;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic [NB*DW-1:0]  bram_read_data_flat;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;

  bram_drain_axis_tx #(.DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .ext_read_mode(ext_read_mode), .ext_read_addr_flat(ext_read_addr_flat),
    .bram_read_data_flat(bram_read_data_flat), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // BRAM array: registered read, data valid one cycle after the address.
  logic [DW-1:0] mem [NB][DEPTH];
  always @(posedge clk)
    for (int i = 0; i < NB; i++)
      bram_read_data_flat[i*DW +: DW] <= mem[i][ext_read_addr_flat[i*AW +: AW]];

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  int cyc = 0, start_cyc, first_valid_cyc, last_valid_cyc, last_hs_cyc, done_cyc;
  int done_cnt, rm_cnt, valid_cnt, stable_err, addr_err;
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic          prev_valid, prev_hs, prev_last;
  logic [DW-1:0] prev_data;

  task automatic clear_stats();
    start_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_cnt = 0; rm_cnt = 0; valid_cnt = 0; stable_err = 0; addr_err = 0;
    got_data.delete(); got_last.delete();
    prev_valid = 1'b0; prev_hs = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy) start_cyc = cyc;
      if (ext_read_mode) rm_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      for (int i = 1; i < NB; i++)
        if (ext_read_addr_flat[i*AW +: AW] !== ext_read_addr_flat[AW-1:0]) addr_err++;
      if (m_axis_tvalid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        last_valid_cyc = cyc;
        if (prev_valid && !prev_hs && (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
          stable_err++;
        if (m_axis_tready) begin
          got_data.push_back(m_axis_tdata);
          got_last.push_back(m_axis_tlast);
          last_hs_cyc = cyc;
        end
      end else if (prev_valid && !prev_hs) begin
        stable_err++;
      end
      prev_valid = m_axis_tvalid;
      prev_hs    = m_axis_tvalid && m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic ready_for(input int mode, input int n);
    if (mode == 0)      return 1'b1;
    else if (mode == 1) return (n % 2 == 0) ? 1'b0 : 1'b1;
    else                return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_drain(input int base, input int rows, input int mode);
    int n;
    clear_stats();
    @(posedge clk); #1;
    base_addr = AW'(base); num_rows = (AW+1)'(rows); start = 1'b1;
    m_axis_tready = ready_for(mode, 1);
    @(posedge clk); #1;
    base_addr = AW'($urandom); num_rows = (AW+1)'($urandom_range(1, 8));
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      start = (n == 4 && busy) ? 1'b1 : 1'b0;   // must be ignored while busy
      m_axis_tready = ready_for(mode, n);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    check("drain_timeout", (n < 3000) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expected stream: row r comes from address (base+r) mod DEPTH, BRAM 0 first.
  task automatic compare_drain(input string tag, input int base, input int rows, input int mode);
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    int bad_d, bad_l, n, exp_rm, exp_span;
    for (int r = 0; r < rows; r++)
      for (int i = 0; i < NB; i++) begin
        exp_data.push_back(mem[i][(base + r) % DEPTH]);
        exp_last.push_back((r == rows - 1) && (i == NB - 1));
      end
    check({tag, "/beats"}, got_data.size(), rows * NB);
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    bad_d = 0; bad_l = 0;
    for (int k = 0; k < n; k++) begin
      if (got_data[k] !== exp_data[k]) bad_d++;
      if (got_last[k] !== exp_last[k]) bad_l++;
    end
    check({tag, "/data_mismatches"}, bad_d, 0);
    check({tag, "/tlast_mismatches"}, bad_l, 0);
    check({tag, "/stable_err"}, stable_err, 0);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/addr_slices"}, addr_err, 0);
    check({tag, "/busy_end"}, busy, 0);
    if (rows > 0) begin
      check({tag, "/first_beat_latency"}, first_valid_cyc - start_cyc, 3);
      check({tag, "/done_after_last"}, done_cyc - last_hs_cyc, 1);
    end else begin
      check({tag, "/valid_cycles"}, valid_cnt, 0);
      check({tag, "/read_mode_cycles"}, rm_cnt, 0);
    end
    if (mode == 0 && rows > 0) begin
`ifdef BRAM_DRAIN_PREFETCH_EN
      exp_rm   = 2 + rows * NB;
      exp_span = rows * NB;
`else
      exp_rm   = rows * (NB + 2);
      exp_span = rows * NB + 2 * (rows - 1);
`endif
      check({tag, "/read_mode_cycles"}, rm_cnt, exp_rm);
      check({tag, "/valid_span"}, last_valid_cyc - first_valid_cyc + 1, exp_span);
      check({tag, "/valid_cycles"}, valid_cnt, rows * NB);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/tvalid"}, m_axis_tvalid, 0);
    check({tag, "/tlast"}, m_axis_tlast, 0);
    check({tag, "/tdata"}, m_axis_tdata, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/read_mode"}, ext_read_mode, 0);
    check({tag, "/read_addr"}, ext_read_addr_flat, 0);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int n, b, r;
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < DEPTH; a++) mem[i][a] = DW'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // One row from address 0 with BRAM i holding i+1
    for (int i = 0; i < NB; i++) mem[i][0] = DW'(i + 1);
    run_drain(0, 1, 0);
    compare_drain("row1", 0, 1, 0);
    if (got_data.size() == NB) begin
      check("row1/first_word", got_data[0], 1);
      check("row1/last_word", got_data[NB-1], NB);
      check("row1/last_flag", got_last[NB-1], 1);
    end else begin
      check("row1/size_for_words", got_data.size(), NB);
    end

    // Address wrap 510,511,0,1
    run_drain(510, 4, 0);
    compare_drain("wrap", 510, 4, 0);

    // Alternating tready
    run_drain(37, 2, 1);
    compare_drain("toggle", 37, 2, 1);

    // Zero rows
    run_drain(12, 0, 0);
    compare_drain("zero_rows", 12, 0, 0);

    // Three rows back-to-back: gap pattern depends on prefetch build
    run_drain(100, 3, 0);
    compare_drain("three_rows", 100, 3, 0);

    // Reset at beat 7 of row 0
    clear_stats();
    @(posedge clk); #1;
    base_addr = AW'(7); num_rows = (AW+1)'(2); start = 1'b1; m_axis_tready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (got_data.size() < 7 && n < 100) begin @(posedge clk); #1; n++; end
    check("midreset/reached_beat7", got_data.size(), 7);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1; rst_n = 1'b1;
    clear_stats();
    repeat (6) @(posedge clk);
    #1;
    check("midreset/no_beats_after", valid_cnt, 0);
    check("midreset/no_read_mode", rm_cnt, 0);
    run_drain(7, 2, 0);
    compare_drain("after_reset", 7, 2, 0);

    // Randomized drains under random backpressure
    for (int t = 0; t < 4; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      r = $urandom_range(1, 5);
      run_drain(b, r, 2);
      compare_drain($sformatf("rand%0d", t), b, r, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_drain_axis_tx.md
BRAM_DRAIN_AXIS_TX -- requirements
Module: bram_drain_axis_tx

Interface
REQ-001 SHALL have parameter DW, default 16, output word width (16-bit fixed-point).
REQ-002 SHALL have parameter NUM_BRAMS, default 16, number of output BRAMs drained in parallel.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, BRAM address width.
REQ-004 SHALL have parameter DEPTH, default 512, BRAM depth.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that launches a drain; ignored while busy=1.
REQ-009 base_addr  input  ADDR_WIDTH  first row address, sampled on accepted start.
REQ-010 num_rows  input  ADDR_WIDTH+1  rows to drain (0..DEPTH), sampled on accepted start.
REQ-011 ext_read_mode  output  1  selects the external read address into the BRAM array.
REQ-012 ext_read_addr_flat  output  NUM_BRAMS*ADDR_WIDTH  read address, identical in every slice.
REQ-013 bram_read_data_flat  input  NUM_BRAMS*DW  BRAM read data; slice i = BRAM i; valid one cycle after its address.
REQ-014 m_axis_tdata  output  DW  stream word.
REQ-015 m_axis_tvalid  output  1  stream valid.
REQ-016 m_axis_tready  input  1  stream ready.
REQ-017 m_axis_tlast  output  1  asserted on the final beat of a drain.
REQ-018 busy  output  1  high from accepted start until done.
REQ-019 done  output  1  one-cycle pulse at drain completion.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, LATCH, SEND, DONE.
REQ-021 IDLE->FETCH on start; FETCH->LATCH next cycle; LATCH->SEND next cycle; SEND->FETCH after beat NUM_BRAMS-1 handshakes if rows remain, else SEND->DONE; DONE->IDLE next cycle.
REQ-022 start with num_rows=0 SHALL go IDLE->DONE: done pulse, no beats, ext_read_mode stays 0.
REQ-023 Row r address SHALL be (base_addr+r) mod DEPTH, i.e. wrap past DEPTH-1 to 0.
REQ-024 ext_read_mode SHALL be 1 in FETCH, LATCH and SEND, 0 in IDLE and DONE.
REQ-025 LATCH SHALL capture all NUM_BRAMS words of bram_read_data_flat into a row buffer.
REQ-026 SEND SHALL emit BRAM 0 word first through BRAM NUM_BRAMS-1, one word per tvalid&&tready.
REQ-027 First beat latency SHALL be 3 cycles: start sampled at edge N -> tvalid high during cycle N+3.
REQ-028 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable and tvalid SHALL not drop.
REQ-029 tlast SHALL be 1 only on word NUM_BRAMS-1 of the last row.
REQ-030 Total beats per drain SHALL equal num_rows*NUM_BRAMS.
REQ-031 busy SHALL be 1 in FETCH, LATCH, SEND and DONE; done SHALL be 1 only in DONE.
REQ-032 start while busy=1 SHALL be ignored and SHALL not alter base_addr, num_rows or the row count.

Reset
REQ-033 Reset SHALL force IDLE, ext_read_mode=0, ext_read_addr_flat=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, and clear counters and the row buffer.
REQ-034 Reset asserted mid-drain SHALL abort at once; no further beats until a new start.

Configuration
REQ-035 With BRAM_DRAIN_PREFETCH_EN defined, SEND SHALL fetch the next row into a second buffer during beats 0-1 and swap it in on the last-beat handshake, giving gapless streaming (tvalid continuous under tready=1).
REQ-036 Without BRAM_DRAIN_PREFETCH_EN, there SHALL be one buffer and a 2-cycle tvalid gap (FETCH, LATCH) between rows.

Structure
REQ-037 Package bram_drain_pkg SHALL hold the FSM state enum and default DW/NUM_BRAMS/ADDR_WIDTH/DEPTH constants.
REQ-038 One sub-module, bram_drain_row_serializer (NUM_BRAMS-to-1 word shifter with beat index), SHALL implement SEND output.

Verification
REQ-039 base_addr=0, num_rows=1, BRAM i word=i+1, tready=1 -> beats 1..16, tlast on beat 16, done one cycle later.
REQ-040 base_addr=510, num_rows=4 -> addresses 510,511,0,1; 64 beats in order.
REQ-041 num_rows=2, tready toggled 1-0-1 every cycle -> 32 beats, no loss or duplication, tdata stable while stalled.
REQ-042 num_rows=0 -> done pulse, zero beats, ext_read_mode never 1.
REQ-043 rst_n low at beat 7 of row 0 -> all outputs at reset values next cycle; new start redrains from row 0.
REQ-044 Prefetch built, num_rows=3, tready=1 -> 48 contiguous tvalid cycles; without prefetch -> 2-cycle gaps after beats 16 and 32.
